// File: rtl/vid_in_axi4s_sc.sv
// Single-clock parallel video capture into an AXI4-Stream video master.
// Marks SOF/EOL, stages one pixel, buffers in a FWFT FIFO with a registered head.
module vid_in_axi4s_sc #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_ADDR_BITS = 5
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  vid_de,
  input  logic                  vid_vsync,
  input  logic [DATA_WIDTH-1:0] vid_data,
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  input  logic                  m_axis_video_tready,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  output logic                  locked,
  output logic                  overflow,
  output logic                  empty
);

  localparam int W     = DATA_WIDTH + 2;
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;

  localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE  = {{(FIFO_ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [FIFO_ADDR_BITS:0]   CNT_ONE  = {{FIFO_ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [FIFO_ADDR_BITS:0]   CNT_ZERO = {(FIFO_ADDR_BITS+1){1'b0}};
  localparam logic [FIFO_ADDR_BITS:0]   CNT_FULL = {1'b1, {FIFO_ADDR_BITS{1'b0}}};

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ARMED   = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_nx_s;
  logic                      prev_vsync_r;
  logic                      vs_rise_s;
  logic                      capture_s;
  logic                      cur_sof_s;
  logic                      sof_pend_r;

  logic                      hold_valid_r;
  logic                      hold_sof_r;
  logic [DATA_WIDTH-1:0]     hold_data_r;
  logic                      line_end_s;

  logic [W-1:0]              mem_r [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_r;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr_r;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr_nx_s;
  logic [FIFO_ADDR_BITS:0]   cnt_r;
  logic [FIFO_ADDR_BITS:0]   cnt_nx_s;
  logic [FIFO_ADDR_BITS:0]   cnt_after_rd_s;
  logic                      full_s;
  logic                      rd_s;
  logic                      wr_s;
  logic                      ovf_s;
  logic [W-1:0]              wr_word_s;
  logic [W-1:0]              head_nx_s;

  logic [DATA_WIDTH-1:0]     tdata_r;
  logic                      tuser_r;
  logic                      tlast_r;
  logic                      tvalid_r;
  logic                      empty_r;
  logic                      locked_r;
  logic                      overflow_r;

  assign vs_rise_s  = vid_vsync & ~prev_vsync_r;
  assign line_end_s = ~vid_de | vs_rise_s;
  assign wr_word_s  = {hold_sof_r, line_end_s, hold_data_r};

  assign full_s = (cnt_r == CNT_FULL);
  assign rd_s   = tvalid_r & m_axis_video_tready;
  // A full FIFO still accepts the write when the head leaves in the same cycle.
  assign wr_s   = hold_valid_r & (~full_s | rd_s);
  assign ovf_s  = hold_valid_r & full_s & ~rd_s;

  // Capture state machine: next state and capture decision.
  always_comb begin
    state_nx_s = state_r;
    capture_s  = 1'b0;
    cur_sof_s  = sof_pend_r | vs_rise_s;
    if (ovf_s) begin
      state_nx_s = WAIT_VS;
    end else begin
      case (state_r)
        WAIT_VS: begin
          if (vs_rise_s) begin
            state_nx_s = ARMED;
          end else begin
            state_nx_s = WAIT_VS;
          end
        end
        ARMED: begin
          if (vid_de) begin
            state_nx_s = ACTIVE;
            capture_s  = 1'b1;
          end else begin
            state_nx_s = ARMED;
          end
        end
        ACTIVE: begin
          capture_s = vid_de;
        end
        default: begin
          state_nx_s = WAIT_VS;
        end
      endcase
    end
  end

  // State, vsync history, SOF-pending and lock/overflow flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= WAIT_VS;
      prev_vsync_r <= 1'b0;
      sof_pend_r   <= 1'b0;
      locked_r     <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      prev_vsync_r <= vid_vsync;
      locked_r     <= (state_nx_s != WAIT_VS);
      overflow_r   <= overflow_r | ovf_s;
      if (ovf_s || capture_s) begin
        sof_pend_r <= 1'b0;
      end else if (vs_rise_s) begin
        sof_pend_r <= 1'b1;
      end
    end
  end

  // One-deep holding register; its tlast is resolved one cycle later.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_valid_r <= 1'b0;
      hold_sof_r   <= 1'b0;
      hold_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      hold_valid_r <= capture_s;
      if (capture_s) begin
        hold_sof_r  <= cur_sof_s;
        hold_data_r <= vid_data;
      end
    end
  end

  // FIFO pointer/count arithmetic and next head word.
  always_comb begin
    rd_ptr_nx_s    = rd_ptr_r;
    cnt_after_rd_s = cnt_r;
    cnt_nx_s       = cnt_r;
    if (rd_s) begin
      rd_ptr_nx_s    = rd_ptr_r + PTR_ONE;
      cnt_after_rd_s = cnt_r - CNT_ONE;
    end else begin
      rd_ptr_nx_s    = rd_ptr_r;
      cnt_after_rd_s = cnt_r;
    end
    case ({wr_s, rd_s})
      2'b10:   cnt_nx_s = cnt_r + CNT_ONE;
      2'b01:   cnt_nx_s = cnt_r - CNT_ONE;
      default: cnt_nx_s = cnt_r;
    endcase
    // Writing into a FIFO that is empty after this read bypasses straight to the head.
    if (wr_s && (cnt_after_rd_s == CNT_ZERO)) begin
      head_nx_s = wr_word_s;
    end else begin
      head_nx_s = mem_r[rd_ptr_nx_s];
    end
  end

  // FIFO storage array.
  always_ff @(posedge aclk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= wr_word_s;
    end
  end

  // FIFO pointers, count and registered stream outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_r <= {FIFO_ADDR_BITS{1'b0}};
      rd_ptr_r <= {FIFO_ADDR_BITS{1'b0}};
      cnt_r    <= CNT_ZERO;
      tvalid_r <= 1'b0;
      empty_r  <= 1'b1;
      tuser_r  <= 1'b0;
      tlast_r  <= 1'b0;
      tdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_ptr_r <= rd_ptr_nx_s;
      cnt_r    <= cnt_nx_s;
      tvalid_r <= (cnt_nx_s != CNT_ZERO);
      empty_r  <= (cnt_nx_s == CNT_ZERO);
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (cnt_nx_s != CNT_ZERO) begin
        {tuser_r, tlast_r, tdata_r} <= head_nx_s;
      end
    end
  end

  assign m_axis_video_tdata  = tdata_r;
  assign m_axis_video_tvalid = tvalid_r;
  assign m_axis_video_tuser  = tuser_r;
  assign m_axis_video_tlast  = tlast_r;
  assign locked              = locked_r;
  assign overflow            = overflow_r;
  assign empty               = empty_r;

endmodule

// File: tb/tb_vid_in_axi4s_sc.sv
// Scoreboard bench for vid_in_axi4s_sc: expected beats are queued as pixels are
// driven and compared as the stream master hands them over.
module tb_vid_in_axi4s_sc;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        vid_de = 1'b0;
  logic        vid_vsync = 1'b0;
  logic [31:0] vid_data = 32'h0;
  logic [31:0] m_axis_video_tdata;
  logic        m_axis_video_tvalid;
  logic        m_axis_video_tready;
  logic        m_axis_video_tuser;
  logic        m_axis_video_tlast;
  logic        locked;
  logic        overflow;
  logic        empty;

  int          total = 0;
  int          bad = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_exp;
  int          rdy_mode = 0;
  int          stall_cnt = 0;

  vid_in_axi4s_sc #(.DATA_WIDTH(32), .FIFO_ADDR_BITS(5)) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .vid_de              (vid_de),
    .vid_vsync           (vid_vsync),
    .vid_data            (vid_data),
    .m_axis_video_tdata  (m_axis_video_tdata),
    .m_axis_video_tvalid (m_axis_video_tvalid),
    .m_axis_video_tready (m_axis_video_tready),
    .m_axis_video_tuser  (m_axis_video_tuser),
    .m_axis_video_tlast  (m_axis_video_tlast),
    .locked              (locked),
    .overflow            (overflow),
    .empty               (empty)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // tready pattern: forced stall window first, then the selected mode
  initial begin
    m_axis_video_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (stall_cnt > 0) begin
        m_axis_video_tready = 1'b0;
        stall_cnt--;
      end else begin
        case (rdy_mode)
          0:       m_axis_video_tready = 1'b1;
          1:       m_axis_video_tready = ~m_axis_video_tready;
          default: m_axis_video_tready = 1'b0;
        endcase
      end
    end
  end

  // stream monitor: handshake pops the scoreboard, a stall must hold the head beat
  always @(negedge aclk) begin
    if (aresetn && m_axis_video_tvalid) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_beat_tvalid", {63'h0, m_axis_video_tvalid}, 64'h0);
      end else if (m_axis_video_tready) begin
        mon_exp = exp_q.pop_front();
        check_eq("beat", {30'h0, m_axis_video_tuser, m_axis_video_tlast, m_axis_video_tdata},
                 {30'h0, mon_exp});
      end else begin
        check_eq("stall_hold", {30'h0, m_axis_video_tuser, m_axis_video_tlast, m_axis_video_tdata},
                 {30'h0, exp_q[0]});
      end
    end
  end

  task automatic vsync_pulse();
    vid_de = 1'b0;
    vid_vsync = 1'b1;
    tick();
    tick();
    vid_vsync = 1'b0;
    tick();
    tick();
  endtask

  // n pixels from base; pixels at index >= push_max are expected to be dropped;
  // vs_at >= 0 raises vsync together with that pixel
  task automatic send_line(input int n, input logic [31:0] base, input bit sof,
                           input int push_max, input int vs_at, input int blank,
                           input bit lat_chk);
    logic u;
    logic l;
    for (int i = 0; i < n; i++) begin
      vid_de = 1'b1;
      vid_data = base + 32'(i);
      vid_vsync = (vs_at >= 0) && (i >= vs_at);
      u = (sof && i == 0) || (i == vs_at);
      l = (i == n - 1) || (i == vs_at - 1);
      if (i < push_max) exp_q.push_back({u, l, base + 32'(i)});
      tick();
      if (lat_chk && i == 0) check_eq("lat_tvalid_n1", {63'h0, m_axis_video_tvalid}, 64'h0);
      if (lat_chk && i == 1) check_eq("lat_tvalid_n2", {63'h0, m_axis_video_tvalid}, 64'h1);
    end
    vid_de = 1'b0;
    vid_vsync = 1'b0;
    repeat (blank) tick();
  endtask

  task automatic send_frame(input int lines, input int ppl, input logic [31:0] base, input int blank);
    vsync_pulse();
    for (int l = 0; l < lines; l++)
      send_line(ppl, base + 32'(l * ppl), l == 0, ppl, -1, blank, 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(exp_q.size()), 64'h0);
    tick();
    tick();
    check_eq({tag, "_empty"}, {63'h0, empty}, 64'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    tick();
    tick();
    check_eq("rst_tvalid", {63'h0, m_axis_video_tvalid}, 64'h0);
    check_eq("rst_empty", {63'h0, empty}, 64'h1);
    check_eq("rst_locked", {63'h0, locked}, 64'h0);
    check_eq("rst_overflow", {63'h0, overflow}, 64'h0);
    check_eq("rst_out", {30'h0, m_axis_video_tuser, m_axis_video_tlast, m_axis_video_tdata}, 64'h0);
    aresetn = 1'b1;
    tick();

    // pixels before any vsync are never emitted
    send_line(8, 32'hA0, 1'b0, 0, -1, 4, 1'b0);
    check_eq("prevs_locked", {63'h0, locked}, 64'h0);
    check_eq("prevs_empty", {63'h0, empty}, 64'h1);

    // locked follows the vsync rise by one cycle
    vid_vsync = 1'b1;
    check_eq("lock_before", {63'h0, locked}, 64'h0);
    tick();
    check_eq("lock_after", {63'h0, locked}, 64'h1);
    tick();
    vid_vsync = 1'b0;
    tick();
    tick();

    // 4x8 frame, incrementing data, tready high, latency checked on line 0
    for (int l = 0; l < 4; l++)
      send_line(8, 32'(l * 8), l == 0, 8, -1, 4, l == 0);
    wait_drain("frame_4x8");

    // tready toggling, 16-pixel lines with 16-cycle blanking
    rdy_mode = 1;
    send_frame(4, 16, 32'h3000, 16);
    wait_drain("toggle");
    rdy_mode = 0;
    check_eq("toggle_no_ovf", {63'h0, overflow}, 64'h0);
    check_eq("toggle_locked", {63'h0, locked}, 64'h1);

    // one-pixel lines
    send_frame(4, 1, 32'h4000, 3);
    wait_drain("one_px");

    // vsync rising together with vid_de, mid-line and on a one-pixel line
    vsync_pulse();
    send_line(8, 32'h5000, 1'b1, 8, 4, 4, 1'b0);
    send_line(1, 32'h5100, 1'b0, 1, 0, 4, 1'b0);
    send_line(4, 32'h5200, 1'b0, 4, -1, 4, 1'b0);
    wait_drain("vs_coincide");
    check_eq("pre_ovf_flag", {63'h0, overflow}, 64'h0);

    // 40-cycle stall during a 64-pixel line: only the first 32 survive
    vsync_pulse();
    stall_cnt = 40;
    send_line(64, 32'h6000, 1'b1, 32, -1, 8, 1'b0);
    check_eq("ovf_flag", {63'h0, overflow}, 64'h1);
    check_eq("ovf_locked", {63'h0, locked}, 64'h0);
    for (int l = 1; l < 3; l++)
      send_line(64, 32'h6000 + 32'(l * 64), 1'b0, 0, -1, 8, 1'b0);
    wait_drain("ovf_drain");
    send_frame(2, 8, 32'h6800, 4);
    wait_drain("ovf_resume");
    check_eq("ovf_sticky", {63'h0, overflow}, 64'h1);
    check_eq("ovf_relocked", {63'h0, locked}, 64'h1);

    // asynchronous reset mid-line with data buffered
    vsync_pulse();
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) begin
      vid_de = 1'b1;
      vid_data = 32'h7000 + 32'(i);
      exp_q.push_back({i == 0, 1'b0, 32'h7000 + 32'(i)});
      tick();
    end
    check_eq("prerst_tvalid", {63'h0, m_axis_video_tvalid}, 64'h1);
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("arst_tvalid", {63'h0, m_axis_video_tvalid}, 64'h0);
    check_eq("arst_empty", {63'h0, empty}, 64'h1);
    check_eq("arst_overflow", {63'h0, overflow}, 64'h0);
    check_eq("arst_locked", {63'h0, locked}, 64'h0);
    exp_q.delete();
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vid_data = 32'h7100 + 32'(i);
      tick();
    end
    vid_de = 1'b0;
    rdy_mode = 0;
    repeat (10) tick();
    check_eq("postrst_quiet", {63'h0, m_axis_video_tvalid}, 64'h0);
    send_frame(2, 4, 32'h7800, 4);
    wait_drain("postrst_frame");
    check_eq("postrst_locked", {63'h0, locked}, 64'h1);
    check_eq("postrst_ovf", {63'h0, overflow}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
